// File: rtl/alu_regfile_core.sv
// Execute core: one-instruction-per-clock decoder, add/sub ALU and a 16-entry register file.
// Optional build macro ZERO_REG_EN makes register 0 read as zero and discard writes.
module alu_regfile_core #(
  parameter int W       = 8,
  parameter int OP_W    = 8,
  parameter int SEL_W   = 4,
  parameter int FLAGS_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [OP_W-1:0]    i0,
  input  logic [W-1:0]       i1,
  input  logic [W-1:0]       i2,
  input  logic [W-1:0]       i3,
  output logic [FLAGS_W-1:0] flags,
  output logic [W-1:0]       result,
  output logic               alu_status,
  input  logic [SEL_W-1:0]   dbg_sel,
  output logic [W-1:0]       dbg_data
);

  localparam int NREG = 2 ** SEL_W;

  // Flag vector is MSB-first: {x_enb, y_enb, z_enb, a_imm, b_imm, illegal}
  localparam int X_BIT   = FLAGS_W - 1;
  localparam int Y_BIT   = FLAGS_W - 2;
  localparam int Z_BIT   = FLAGS_W - 3;
  localparam int A_BIT   = FLAGS_W - 4;
  localparam int B_BIT   = FLAGS_W - 5;
  localparam int ILL_BIT = FLAGS_W - 6;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUBI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5);

  logic [FLAGS_W-1:0] dec_flags;
  logic               dec_op;

  logic [FLAGS_W-1:0] d_flags;
  logic               d_op;
  logic [W-1:0]       d_a1;
  logic [W-1:0]       d_a2;
  logic [SEL_W-1:0]   d_z_sel;

  logic [W-1:0]       regs [NREG];
  logic [W-1:0]       rd_x;
  logic [W-1:0]       rd_y;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic [W:0]         alu_ext;
  logic               alu_stat;

  // Destination select only needs its low bits; the rest of i3 is ignored.
  logic unused_i3_hi;
  assign unused_i3_hi = ^i3[W-1:SEL_W];

  always_comb begin
    dec_flags = '0;
    dec_op    = 1'b0;
    case (i0)
      OP_NOP: ;
      OP_ADD: begin
        dec_flags[X_BIT] = 1'b1;
        dec_flags[Y_BIT] = 1'b1;
        dec_flags[Z_BIT] = 1'b1;
      end
      OP_SUB: begin
        dec_flags[X_BIT] = 1'b1;
        dec_flags[Y_BIT] = 1'b1;
        dec_flags[Z_BIT] = 1'b1;
        dec_op           = 1'b1;
      end
      OP_ADDI: begin
        dec_flags[X_BIT] = 1'b1;
        dec_flags[Z_BIT] = 1'b1;
        dec_flags[B_BIT] = 1'b1;
      end
      OP_SUBI: begin
        dec_flags[X_BIT] = 1'b1;
        dec_flags[Z_BIT] = 1'b1;
        dec_flags[B_BIT] = 1'b1;
        dec_op           = 1'b1;
      end
      OP_LDI: begin
        dec_flags[Z_BIT] = 1'b1;
        dec_flags[A_BIT] = 1'b1;
      end
      default: dec_flags[ILL_BIT] = 1'b1;
    endcase
  end

  // Decode latch; reset forces a NOP so nothing is pending after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_flags <= '0;
      d_op    <= 1'b0;
      d_a1    <= '0;
      d_a2    <= '0;
      d_z_sel <= '0;
    end else begin
      d_flags <= dec_flags;
      d_op    <= dec_op;
      d_a1    <= i1;
      d_a2    <= i2;
      d_z_sel <= i3[SEL_W-1:0];
    end
  end

  always_comb begin
    rd_x     = regs[d_a1[SEL_W-1:0]];
    rd_y     = regs[d_a2[SEL_W-1:0]];
    dbg_data = regs[dbg_sel];
`ifdef ZERO_REG_EN
    if (d_a1[SEL_W-1:0] == '0) rd_x = '0;
    if (d_a2[SEL_W-1:0] == '0) rd_y = '0;
    if (dbg_sel == '0)         dbg_data = '0;
`endif
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (d_flags[A_BIT])      op_a = d_a1;
    else if (d_flags[X_BIT]) op_a = rd_x;
    if (d_flags[B_BIT])      op_b = d_a2;
    else if (d_flags[Y_BIT]) op_b = rd_y;
  end

  // One extra bit holds carry for add and borrow (a < b) for sub.
  always_comb begin
    if (d_op) alu_ext = {1'b0, op_a} - {1'b0, op_b};
    else      alu_ext = {1'b0, op_a} + {1'b0, op_b};
    result   = alu_ext[W-1:0];
    alu_stat = alu_ext[W];
  end

  assign flags = d_flags;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_status <= 1'b0;
    end else if (d_flags[Z_BIT]) begin
`ifdef ZERO_REG_EN
      if (d_z_sel != '0) regs[d_z_sel] <= result;
`else
      regs[d_z_sel] <= result;
`endif
      alu_status <= alu_stat;
    end
  end

endmodule

// File: tb/tb_alu_regfile_core.sv
// Directed bench for alu_regfile_core: hand-computed vectors checked with immediate assertions.
module tb_alu_regfile_core;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] i0, i1, i2, i3;
  logic [5:0] flags;
  logic [7:0] result;
  logic       alu_status;
  logic [3:0] dbg_sel;
  logic [7:0] dbg_data;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [7:0] NOP = 8'h00, ADD = 8'h01, SUB = 8'h02,
                         ADDI = 8'h03, SUBI = 8'h04, LDI = 8'h05;

  alu_regfile_core dut (
    .clock(clock), .reset(reset),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .flags(flags), .result(result), .alu_status(alu_status),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Apply one instruction before a rising edge; returns 1ns after that edge (decoded).
  task automatic step(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3);
    @(negedge clock);
    i0 = op; i1 = a1; i2 = a2; i3 = a3;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    dbg_sel = idx[3:0];
    #1;
    check($sformatf("r%0d", idx), dbg_data, exp);
  endtask

  initial begin
    reset = 1'b1; i0 = NOP; i1 = '0; i2 = '0; i3 = '0; dbg_sel = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_flags", {2'b00, flags}, 8'h00);
    check("rst_result", result, 8'h00);
    check("rst_status", {7'b0, alu_status}, 8'h00);
    for (int r = 0; r < 16; r++) check_reg(r, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Basic load/add
    step(LDI, 8'h05, 8'h00, 8'h01);
    check("ldi_flags", {2'b00, flags}, 8'b0000_1100);
    check("ldi_result", result, 8'h05);
    step(LDI, 8'h03, 8'h00, 8'h02);
    step(ADD, 8'h01, 8'h02, 8'h03);
    check("add_flags", {2'b00, flags}, 8'b0011_1000);
    check("add_result", result, 8'h08);
    step(NOP, 8'h00, 8'h00, 8'h00);
    check("nop_flags", {2'b00, flags}, 8'h00);
    check("nop_result", result, 8'h00);
    check("add_status", {7'b0, alu_status}, 8'h00);
    check_reg(1, 8'h05);
    check_reg(2, 8'h03);
    check_reg(3, 8'h08);

    // Wrap-around add carry, then sub borrow (upper select bits set, must be ignored)
    step(LDI, 8'hFF, 8'h00, 8'h01);
    step(ADDI, 8'hF1, 8'h01, 8'h04);
    check("addi_flags", {2'b00, flags}, 8'b0010_1010);
    check("addi_result", result, 8'h00);
    step(SUB, 8'h04, 8'h31, 8'hA5);
    check("addi_status", {7'b0, alu_status}, 8'h01);
    check("sub_result", result, 8'h01);
    step(NOP, 8'h00, 8'h00, 8'h00);
    check("sub_status", {7'b0, alu_status}, 8'h01);
    check_reg(4, 8'h00);
    check_reg(5, 8'h01);

    // Back-to-back dependency
    step(LDI, 8'h10, 8'h00, 8'h06);
    step(ADDI, 8'h06, 8'h01, 8'h06);
    check("dep_result", result, 8'h11);
    step(NOP, 8'h00, 8'h00, 8'h00);
    check_reg(6, 8'h11);
    check("dep_status", {7'b0, alu_status}, 8'h00);

    // SUBI with borrow sets status; illegal opcode must not disturb it
    step(SUBI, 8'h02, 8'h04, 8'h07);
    check("subi_result", result, 8'hFF);
    step(8'h7F, 8'h01, 8'h02, 8'h03);
    check("ill_flags", {2'b00, flags}, 8'b0000_0001);
    check("ill_result", result, 8'h00);
    step(NOP, 8'h00, 8'h00, 8'h00);
    check("ill_status", {7'b0, alu_status}, 8'h01);
    check_reg(3, 8'h08);
    check_reg(7, 8'hFF);
    check_reg(1, 8'hFF);

    // Register 0 behaviour
    step(LDI, 8'hAA, 8'h00, 8'h00);
    step(ADD, 8'h00, 8'h01, 8'h08);
`ifdef ZERO_REG_EN
    check("r0_add_result", result, 8'hFF);
`else
    check("r0_add_result", result, 8'hA9);
`endif
    step(NOP, 8'h00, 8'h00, 8'h00);
`ifdef ZERO_REG_EN
    check_reg(0, 8'h00);
    check("r0_status", {7'b0, alu_status}, 8'h00);
`else
    check_reg(0, 8'hAA);
    check("r0_status", {7'b0, alu_status}, 8'h01);
`endif

    // Reset during an ADD decode cycle discards the pending writeback
    step(ADD, 8'h01, 8'h01, 8'h09);
    check("pre_rst_result", result, 8'hFE);
    @(negedge clock);
    reset = 1'b1;
    i0 = NOP;
    @(posedge clock);
    #1;
    check("mid_rst_flags", {2'b00, flags}, 8'h00);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_status", {7'b0, alu_status}, 8'h00);
    for (int r = 0; r < 16; r++) check_reg(r, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Post-reset sanity: machine still works
    step(LDI, 8'h3C, 8'h00, 8'h0F);
    step(NOP, 8'h00, 8'h00, 8'h00);
    check_reg(15, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
